// File: rtl/startup_pkg.sv
// startup_pkg
// Shared definitions for the startup sequencer: FSM state encoding (also
// exported on state_dbg), synchronizer depth and debug-port width.
package startup_pkg;

  // Flops per input synchronizer.
  localparam int SYNC_STAGES = 2;

  // Width of the exported state encoding.
  localparam int STATE_DBG_W = 3;

  typedef enum logic [STATE_DBG_W-1:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_GTS_REL   = 3'd3,
    ST_DONE      = 3'd4
  } startup_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Single-bit flop-chain synchronizer bringing an asynchronous level into the
// i_clk domain. Reset is asynchronous active-low and clears the chain to 0.
//
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input level
//   o_q     - synchronized level (SYNC_STAGES edges of latency)
module sync_2ff
  import startup_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/startup_sequencer.sv
// startup_sequencer
// Power-on sequencer sitting between the clock/PLL block and every reset
// consumer. It waits for a stable PLL lock, releases the per-domain resets
// one at a time (bit 0 first), then drops the global tristate hold and flags
// completion. A global reset request or loss of lock at any point after
// WAIT_LOCK throws everything back to the reset values.
// Parameters must satisfy LOCK_STABLE_CYCLES >= 1, STAGES >= 1,
// STAGE_GAP >= 1.
//
// Ports:
//   sys_clk    - the only clock
//   sys_rst_n  - asynchronous active-low reset
//   gsr_req    - asynchronous global reset request (active-high)
//   pll_locked - asynchronous PLL lock indication
//   rst_out    - active-high per-domain resets, bit 0 released first
//   gts_out    - global tristate hold (pads tristated while high)
//   done       - startup complete
//   state_dbg  - current FSM state encoding
module startup_sequencer
  import startup_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGES             = 3,
  parameter int STAGE_GAP          = 16
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   gsr_req,
  input  logic                   pll_locked,
  output logic [STAGES-1:0]      rst_out,
  output logic                   gts_out,
  output logic                   done,
  output logic [STATE_DBG_W-1:0] state_dbg
);

  // One counter serves both the lock-stability wait and the stage gaps, so it
  // is sized for the larger of the two terminal counts.
  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);

  logic w_gsr_s;
  logic w_lock_s;

  sync_2ff u_sync_gsr (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (gsr_req),
    .o_q     (w_gsr_s)
  );

  sync_2ff u_sync_lock (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst_n),
    .i_d     (pll_locked),
    .o_q     (w_lock_s)
  );

  startup_state_t    r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt, w_cnt_next;
  logic [STAGES-1:0] r_rst_out, w_rst_out_next;
  logic              r_gts, w_gts_next;
  logic              r_done, w_done_next;
  logic              w_abort;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= '0;
      r_rst_out <= '1;
      r_gts     <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rst_out <= w_rst_out_next;
      r_gts     <= w_gts_next;
      r_done    <= w_done_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_rst_out_next = r_rst_out;
    w_gts_next     = r_gts;
    w_done_next    = r_done;

    // Abort outranks every other transition, including the one out of DONE.
    w_abort = (r_state != ST_WAIT_LOCK) && (w_gsr_s || !w_lock_s);

    if (w_abort) begin
      w_state_next   = ST_WAIT_LOCK;
      w_cnt_next     = '0;
      w_rst_out_next = '1;
      w_gts_next     = 1'b1;
      w_done_next    = 1'b0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          w_cnt_next     = '0;
          w_rst_out_next = '1;
          w_gts_next     = 1'b1;
          w_done_next    = 1'b0;
          if (w_lock_s && !w_gsr_s) begin
            w_state_next = ST_STABLE;
          end
        end

        // lock_s is known high here, otherwise the abort branch was taken.
        ST_STABLE: begin
          if (r_cnt == LOCK_LAST) begin
            w_state_next   = ST_RELEASE;
            w_cnt_next     = '0;
            w_rst_out_next = r_rst_out << 1;
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        // Shifting left clears the lowest still-set bit, giving ascending
        // release order. Once every bit is clear, one more gap elapses before
        // the tristate hold drops.
        ST_RELEASE: begin
          if (r_cnt == GAP_LAST) begin
            w_cnt_next = '0;
            if (r_rst_out == '0) begin
              w_state_next = ST_GTS_REL;
              w_gts_next   = 1'b0;
              w_done_next  = 1'b1;
            end else begin
              w_rst_out_next = r_rst_out << 1;
            end
          end else begin
            w_cnt_next = r_cnt + 1'b1;
          end
        end

        ST_GTS_REL: begin
          w_state_next = ST_DONE;
        end

        ST_DONE: begin
          w_state_next = ST_DONE;
        end

        default: begin
          w_state_next   = ST_WAIT_LOCK;
          w_cnt_next     = '0;
          w_rst_out_next = '1;
          w_gts_next     = 1'b1;
          w_done_next    = 1'b0;
        end
      endcase
    end
  end

  assign rst_out   = r_rst_out;
  assign gts_out   = r_gts;
  assign done      = r_done;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_startup_sequencer.sv
// tb_startup_sequencer
// Two instances: A with LOCK_STABLE_CYCLES=8, STAGES=3, STAGE_GAP=4 and B
// with all parameters at 1. Each test fills a table of per-edge input
// updates and expected outputs; expectations go into a scoreboard queue when
// the table is launched and a negedge monitor pops and compares them at the
// edge they are due. Edge 0 is the first rising edge after a table starts.
module tb_startup_sequencer;
  import startup_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_gsr, a_pll;
  logic [2:0] a_rst_out;
  logic       a_gts, a_done;
  logic [2:0] a_st;

  logic       b_rst_n, b_gsr, b_pll;
  logic [0:0] b_rst_out;
  logic       b_gts, b_done;
  logic [2:0] b_st;

  startup_sequencer #(
    .LOCK_STABLE_CYCLES (8),
    .STAGES             (3),
    .STAGE_GAP          (4)
  ) u_dut_a (
    .sys_clk    (clk),
    .sys_rst_n  (a_rst_n),
    .gsr_req    (a_gsr),
    .pll_locked (a_pll),
    .rst_out    (a_rst_out),
    .gts_out    (a_gts),
    .done       (a_done),
    .state_dbg  (a_st)
  );

  startup_sequencer #(
    .LOCK_STABLE_CYCLES (1),
    .STAGES             (1),
    .STAGE_GAP          (1)
  ) u_dut_b (
    .sys_clk    (clk),
    .sys_rst_n  (b_rst_n),
    .gsr_req    (b_gsr),
    .pll_locked (b_pll),
    .rst_out    (b_rst_out),
    .gts_out    (b_gts),
    .done       (b_done),
    .state_dbg  (b_st)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // One table row: after edge 'at' the outputs must equal 'exp', then the
  // inputs take the row's pll/gsr values.
  typedef struct {
    int         at;
    bit         dut;
    logic       pll;
    logic       gsr;
    logic [7:0] exp;
  } vec_t;

  typedef struct {
    int         abs_edge;
    int         rel;
    bit         dut;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb_q[$];

  function automatic logic [7:0] pk(logic [2:0] r, logic g, logic d, logic [2:0] s);
    return {r, g, d, s};
  endfunction

  function automatic logic [7:0] actual(bit dut);
    if (dut) return {2'b00, b_rst_out, b_gts, b_done, b_st};
    return {a_rst_out, a_gts, a_done, a_st};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rst=%b gts=%b done=%b st=%0d, want rst=%b gts=%b done=%b st=%0d",
               name, got[7:5], got[4], got[3], got[2:0], exp[7:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  task automatic add(input int at, input bit dut, input logic pll, input logic gsr,
                     input logic [2:0] r, input logic g, input logic d, input logic [2:0] s);
    vec_t v;
    v.at  = at;
    v.dut = dut;
    v.pll = pll;
    v.gsr = gsr;
    v.exp = pk(r, g, d, s);
    tbl.push_back(v);
  endtask

  task automatic set_in(input bit dut, input logic pll, input logic gsr);
    if (dut) begin
      b_pll = pll;
      b_gsr = gsr;
    end else begin
      a_pll = pll;
      a_gsr = gsr;
    end
  endtask

  // Monitor: compares every scoreboard entry that has come due.
  always @(negedge clk) begin : monitor
    sb_t e;
    while (sb_q.size() > 0 && sb_q[0].abs_edge <= edge_cnt) begin
      e = sb_q.pop_front();
      if (e.abs_edge < edge_cnt) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s@%0d: sample missed, now at edge %0d", e.tag, e.rel, edge_cnt);
      end else begin
        check($sformatf("%s@%0d", e.tag, e.rel), actual(e.dut), e.exp);
      end
    end
  end

  // Must be called right after a falling edge. Drives the initial inputs,
  // queues all expectations, then applies the row inputs as each edge passes.
  task automatic play(input string tag, input logic pll0, input logic gsr0);
    int  base;
    int  guard;
    bit  dut;
    sb_t e;
    dut  = tbl[0].dut;
    set_in(dut, pll0, gsr0);
    base = edge_cnt;
    foreach (tbl[i]) begin
      e.abs_edge = base + 1 + tbl[i].at;
      e.rel      = tbl[i].at;
      e.dut      = dut;
      e.exp      = tbl[i].exp;
      e.tag      = tag;
      sb_q.push_back(e);
    end
    foreach (tbl[i]) begin
      guard = 0;
      while (edge_cnt < base + 1 + tbl[i].at && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      set_in(dut, tbl[i].pll, tbl[i].gsr);
    end
    guard = 0;
    while (sb_q.size() > 0 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard not drained, %0d entries left", tag, sb_q.size());
      sb_q.delete();
    end
    tbl.delete();
  endtask

  // Asserts reset at a falling edge, checks the reset values, and releases it
  // on a later falling edge.
  task automatic do_reset(input bit dut);
    if (dut) b_rst_n = 1'b0; else a_rst_n = 1'b0;
    set_in(dut, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check(dut ? "reset_state_b" : "reset_state_a", actual(dut),
          dut ? pk(3'b001, 1'b1, 1'b0, 3'd0) : pk(3'b111, 1'b1, 1'b0, 3'd0));
    if (dut) b_rst_n = 1'b1; else a_rst_n = 1'b1;
  endtask

  task automatic load_nominal(input int last);
    add(0,  0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(1,  0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(2,  0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(9,  0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(10, 0, 1, 0, 3'b110, 1, 0, 3'd2);
    add(13, 0, 1, 0, 3'b110, 1, 0, 3'd2);
    add(14, 0, 1, 0, 3'b100, 1, 0, 3'd2);
    if (last > 14) begin
      add(17, 0, 1, 0, 3'b100, 1, 0, 3'd2);
      add(18, 0, 1, 0, 3'b000, 1, 0, 3'd2);
      add(21, 0, 1, 0, 3'b000, 1, 0, 3'd2);
      add(22, 0, 1, 0, 3'b000, 0, 1, 3'd3);
      add(23, 0, 1, 0, 3'b000, 0, 1, 3'd4);
      add(30, 0, 1, 0, 3'b000, 0, 1, 3'd4);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_rst_n = 1'b0; a_gsr = 1'b0; a_pll = 1'b0;
    b_rst_n = 1'b0; b_gsr = 1'b0; b_pll = 1'b0;
    @(negedge clk);
    do_reset(1);
    do_reset(0);

    // Nominal release timeline.
    load_nominal(30);
    play("nominal", 1'b1, 1'b0);

    // Three-cycle gsr_req pulse while in DONE, then a full repeat.
    add(0,  0, 1, 1, 3'b000, 0, 1, 3'd4);
    add(1,  0, 1, 1, 3'b000, 0, 1, 3'd4);
    add(2,  0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(4,  0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(5,  0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(12, 0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(13, 0, 1, 0, 3'b110, 1, 0, 3'd2);
    add(17, 0, 1, 0, 3'b100, 1, 0, 3'd2);
    add(21, 0, 1, 0, 3'b000, 1, 0, 3'd2);
    add(25, 0, 1, 0, 3'b000, 0, 1, 3'd3);
    add(26, 0, 1, 0, 3'b000, 0, 1, 3'd4);
    play("gsr_in_done", 1'b1, 1'b1);

    // pll_locked low for edges 6 and 7 during STABLE: count restarts.
    do_reset(0);
    add(5,  0, 0, 0, 3'b111, 1, 0, 3'd1);
    add(7,  0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(8,  0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(9,  0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(10, 0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(17, 0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(18, 0, 1, 0, 3'b110, 1, 0, 3'd2);
    play("lock_glitch", 1'b1, 1'b0);

    // sys_rst_n asserted mid-RELEASE with rst_out = 3'b100.
    do_reset(0);
    load_nominal(14);
    play("pre_async_rst", 1'b1, 1'b0);
    check("mid_release", actual(0), pk(3'b100, 1'b1, 1'b0, 3'd2));
    #2 a_rst_n = 1'b0;
    #1 check("async_reset", actual(0), pk(3'b111, 1'b1, 1'b0, 3'd0));
    @(negedge clk);
    check("async_reset_hold", actual(0), pk(3'b111, 1'b1, 1'b0, 3'd0));
    @(negedge clk);
    a_rst_n = 1'b1;
    load_nominal(30);
    play("after_async_rst", 1'b1, 1'b0);

    // gsr_req and pll_locked both high from edge 0; gsr_req drops before edge 12.
    do_reset(0);
    add(2,  0, 1, 1, 3'b111, 1, 0, 3'd0);
    add(6,  0, 1, 1, 3'b111, 1, 0, 3'd0);
    add(11, 0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(13, 0, 1, 0, 3'b111, 1, 0, 3'd0);
    add(21, 0, 1, 0, 3'b111, 1, 0, 3'd1);
    add(22, 0, 1, 0, 3'b110, 1, 0, 3'd2);
    play("simultaneous", 1'b1, 1'b1);

    // Minimal configuration on instance B.
    add(0, 1, 1, 0, 3'b001, 1, 0, 3'd0);
    add(1, 1, 1, 0, 3'b001, 1, 0, 3'd0);
    add(2, 1, 1, 0, 3'b001, 1, 0, 3'd1);
    add(3, 1, 1, 0, 3'b000, 1, 0, 3'd2);
    add(4, 1, 1, 0, 3'b000, 0, 1, 3'd3);
    add(5, 1, 1, 0, 3'b000, 0, 1, 3'd4);
    play("edge_cfg", 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
